// File: rtl/mem_rw_pkg.sv
// Shared definitions for the DPRAM manual I/O / self-test controller.
//   state_t      : controller states (manual ops, self-test walk, end)
//   BTN_*        : bit positions of the buttons inside the packed button vector
//   DISP_TIMEOUT : display value shown after a memory handshake timeout
//   pattern()    : self-test data word; address bits replicated across the
//                  word then XORed with the seed (caller truncates to DW)
package mem_rw_pkg;

    typedef enum logic [3:0] {
        IDLE,
        M_WR,
        M_RD,
        T_WR,
        T_WR_WAIT,
        T_RD,
        T_RD_WAIT,
        T_CMP,
        T_END
    } state_t;

    localparam int BTN_A  = 0;
    localparam int BTN_RD = 1;
    localparam int BTN_WR = 2;
    localparam int BTN_IT = 3;

    localparam logic [15:0] DISP_TIMEOUT = 16'hDEAD;

    function automatic logic [63:0] pattern(input logic [63:0] addr,
                                            input int          aw,
                                            input logic [63:0] seed);
        logic [63:0] a_m;
        logic [63:0] rep;
        a_m = addr & ((64'd1 << aw) - 64'd1);
        rep = '0;
        for (int k = 0; k < 64; k++) begin
            if (k * aw < 64) begin
                rep = rep | (a_m << (k * aw));
            end
        end
        return rep ^ seed;
    endfunction

endpackage

// File: rtl/mem_rw_tester_btn_edge.sv
// Button rising-edge detector.
//   clk_i   : system clock
//   ar_i    : synchronous active-low reset
//   btn_i   : button levels (already synchronised upstream)
//   pulse_o : one-cycle pulse on each 0->1 transition; a held button fires once
module btn_edge #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         ar_i,
    input  logic [N-1:0] btn_i,
    output logic [N-1:0] pulse_o
);

    logic [N-1:0] btn_q;

    always_ff @(posedge clk_i) begin
        if (!ar_i) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn_i;
        end
    end

    assign pulse_o = btn_i & ~btn_q;

endmodule

// File: rtl/mem_rw_tester.sv
// Manual I/O and built-in self-test controller for the on-chip DPRAM.
//   clk, ar                : clock, synchronous active-low reset
//   universal_in           : switches; address (low AW bits) or write data
//   dout, done             : memory read data and one-cycle completion ack
//   a/rd/wr/it_button      : latch address, manual read, manual write, self-test
//   a, din, rd, wr         : memory port; strobes held until done is sampled
//   done_led/pass_led/fail_led : status
//   seg0..seg3             : nibbles [3:0]..[15:12] of the 16-bit display register
module mem_rw_tester
    import mem_rw_pkg::*;
#(
    parameter int            AW          = 10,
    parameter int            DW          = 16,
    parameter logic [DW-1:0] SEED        = DW'(16'hA5C3),
    parameter int            TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          ar,
    input  logic [DW-1:0] universal_in,
    input  logic [DW-1:0] dout,
    input  logic          done,
    input  logic          a_button,
    input  logic          rd_button,
    input  logic          wr_button,
    input  logic          it_button,
    output logic [AW-1:0] a,
    output logic [DW-1:0] din,
    output logic          rd,
    output logic          wr,
    output logic          done_led,
    output logic          pass_led,
    output logic          fail_led,
    output logic [3:0]    seg0,
    output logic [3:0]    seg1,
    output logic [3:0]    seg2,
    output logic [3:0]    seg3
);

    // Timeout counter is at least 8 bits wide.
    localparam int TW = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);

    state_t        state_q;
    logic [AW-1:0] a_q;
    logic [AW-1:0] save_a_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] rdata_q;
    logic          rd_q;
    logic          wr_q;
    logic          done_led_q;
    logic          pass_q;
    logic          fail_q;
    logic [15:0]   disp_q;
    logic [TW-1:0] tmo_q;

    logic [3:0]    edge_w;
    logic [DW-1:0] pat_w;
    logic          waiting_w;
    logic          tmo_hit_w;
    logic          last_addr_w;

    btn_edge #(.N(4)) u_btn_edge (
        .clk_i   (clk),
        .ar_i    (ar),
        .btn_i   ({it_button, wr_button, rd_button, a_button}),
        .pulse_o (edge_w)
    );

    assign pat_w       = DW'(pattern(64'(a_q), AW, 64'(SEED)));
    assign waiting_w   = (state_q == M_WR) || (state_q == M_RD) ||
                         (state_q == T_WR_WAIT) || (state_q == T_RD_WAIT);
    assign tmo_hit_w   = (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign last_addr_w = (a_q == {AW{1'b1}});

    always_ff @(posedge clk) begin
        if (!ar) begin
            state_q    <= IDLE;
            a_q        <= '0;
            save_a_q   <= '0;
            din_q      <= '0;
            rdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            done_led_q <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            disp_q     <= '0;
            tmo_q      <= '0;
        end else if (waiting_w && !done && tmo_hit_w) begin
            // Handshake abort: a late done in the same cycle still wins above.
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            fail_q     <= 1'b1;
            pass_q     <= 1'b0;
            disp_q     <= DISP_TIMEOUT;
            done_led_q <= 1'b1;
            state_q    <= IDLE;
            if ((state_q == T_WR_WAIT) || (state_q == T_RD_WAIT)) begin
                a_q <= save_a_q;
            end
        end else begin
            if (waiting_w && !done) begin
                tmo_q <= tmo_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (edge_w[BTN_IT]) begin
                        save_a_q   <= a_q;
                        a_q        <= '0;
                        pass_q     <= 1'b0;
                        fail_q     <= 1'b0;
                        done_led_q <= 1'b0;
                        state_q    <= T_WR;
                    end else if (edge_w[BTN_WR]) begin
                        wr_q       <= 1'b1;
                        tmo_q      <= '0;
                        done_led_q <= 1'b0;
                        state_q    <= M_WR;
                    end else if (edge_w[BTN_RD]) begin
                        rd_q       <= 1'b1;
                        tmo_q      <= '0;
                        done_led_q <= 1'b0;
                        state_q    <= M_RD;
                    end else if (edge_w[BTN_A]) begin
                        a_q <= universal_in[AW-1:0];
                    end else begin
                        din_q <= universal_in;
                    end
                end
                M_WR: begin
                    if (done) begin
                        wr_q       <= 1'b0;
                        done_led_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                M_RD: begin
                    if (done) begin
                        rd_q       <= 1'b0;
                        done_led_q <= 1'b1;
                        disp_q     <= 16'(dout);
                        state_q    <= IDLE;
                    end
                end
                T_WR: begin
                    din_q   <= pat_w;
                    wr_q    <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= T_WR_WAIT;
                end
                T_WR_WAIT: begin
                    if (done) begin
                        wr_q <= 1'b0;
                        if (last_addr_w) begin
                            a_q     <= '0;
                            state_q <= T_RD;
                        end else begin
                            a_q     <= a_q + 1'b1;
                            state_q <= T_WR;
                        end
                    end
                end
                T_RD: begin
                    rd_q    <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= T_RD_WAIT;
                end
                T_RD_WAIT: begin
                    if (done) begin
                        rd_q    <= 1'b0;
                        rdata_q <= dout;
                        state_q <= T_CMP;
                    end
                end
                T_CMP: begin
                    if (rdata_q != pat_w) begin
                        fail_q  <= 1'b1;
                        disp_q  <= 16'(a_q);
                        state_q <= T_END;
                    end else if (last_addr_w) begin
                        pass_q  <= 1'b1;
                        disp_q  <= '0;
                        state_q <= T_END;
                    end else begin
                        a_q     <= a_q + 1'b1;
                        state_q <= T_RD;
                    end
                end
                T_END: begin
                    done_led_q <= 1'b1;
                    a_q        <= save_a_q;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a        = a_q;
    assign din      = din_q;
    assign rd       = rd_q;
    assign wr       = wr_q;
    assign done_led = done_led_q;
    assign pass_led = pass_q;
    assign fail_led = fail_q;
    assign seg0     = disp_q[3:0];
    assign seg1     = disp_q[7:4];
    assign seg2     = disp_q[11:8];
    assign seg3     = disp_q[15:12];

endmodule

// File: tb/tb_mem_rw_tester.sv
module tb_mem_rw_tester;

    localparam int          AW    = 10;
    localparam int          DW    = 16;
    localparam int          TO    = 255;
    localparam int          DEPTH = 1 << AW;
    localparam logic [15:0] SEED  = 16'hA5C3;

    logic          clk = 1'b0;
    logic          ar  = 1'b0;
    logic [DW-1:0] universal_in = '0;
    logic [DW-1:0] dout = '0;
    logic          done = 1'b0;
    logic          a_button = 1'b0, rd_button = 1'b0, wr_button = 1'b0, it_button = 1'b0;
    logic [AW-1:0] a;
    logic [DW-1:0] din;
    logic          rd, wr, done_led, pass_led, fail_led;
    logic [3:0]    seg0, seg1, seg2, seg3;

    mem_rw_tester #(.AW(AW), .DW(DW), .SEED(SEED), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .ar(ar), .universal_in(universal_in), .dout(dout), .done(done),
        .a_button(a_button), .rd_button(rd_button), .wr_button(wr_button),
        .it_button(it_button), .a(a), .din(din), .rd(rd), .wr(wr),
        .done_led(done_led), .pass_led(pass_led), .fail_led(fail_led),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference pattern: the address concatenated with itself, low DW bits, XOR seed.
    function automatic logic [DW-1:0] ref_pat(input logic [AW-1:0] ad);
        logic [4*AW-1:0] rep;
        rep = {4{ad}};
        return rep[DW-1:0] ^ SEED;
    endfunction

    // Memory model: acks after a per-transaction latency, stores writes, serves reads.
    logic [DW-1:0] mem [DEPTH];
    int            fixed_lat = 0;     // <0 selects a random latency 0..2 per access
    bit            hang_rd = 0;
    int            corrupt_addr = -1;
    bit            in_test = 0;
    int            cnt = 0, lat_cur = 0;
    int            wr_hi = 0, rd_hi = 0, wr_cnt = 0, rd_cnt = 0, tw = 0, tr = 0;
    logic [AW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;

    always @(negedge clk) begin
        if (wr === 1'b1) wr_hi++;
        if (rd === 1'b1) rd_hi++;
        if (!in_test) begin
            tw = 0;
            tr = 0;
        end
        if (!ar || done || !(wr || rd)) begin
            done = 1'b0;
            cnt  = 0;
        end else begin
            if (cnt == 0) lat_cur = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
            cnt++;
            if (cnt > lat_cur && !(rd && hang_rd)) begin
                done = 1'b1;
                if (wr) begin
                    mem[a]  = din;
                    last_wa = a;
                    last_wd = din;
                    wr_cnt++;
                    if (in_test) begin
                        check("st_wr_addr", 64'(a), 64'(tw));
                        check("st_wr_data", 64'(din), 64'(ref_pat(a)));
                        tw++;
                    end
                end else begin
                    dout = mem[a] ^ ((int'(a) == corrupt_addr) ? DW'(1) : DW'(0));
                    rd_cnt++;
                    if (in_test) begin
                        check("st_rd_addr", 64'(a), 64'(tr));
                        tr++;
                    end
                end
            end
        end
    end

    // mask bits: 0=a, 1=rd, 2=wr, 3=it
    task automatic press(input logic [3:0] mask);
        @(negedge clk);
        if (mask[0]) a_button  = 1'b1;
        if (mask[1]) rd_button = 1'b1;
        if (mask[2]) wr_button = 1'b1;
        if (mask[3]) it_button = 1'b1;
        @(negedge clk);
        if (mask[0]) a_button  = 1'b0;
        if (mask[1]) rd_button = 1'b0;
        if (mask[2]) wr_button = 1'b0;
        if (mask[3]) it_button = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_led !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_in_time"}, 64'(done_led), 64'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, 64'(a), 0);
        check({tag, "_din"}, 64'(din), 0);
        check({tag, "_rd"}, 64'(rd), 0);
        check({tag, "_wr"}, 64'(wr), 0);
        check({tag, "_done_led"}, 64'(done_led), 0);
        check({tag, "_pass"}, 64'(pass_led), 0);
        check({tag, "_fail"}, 64'(fail_led), 0);
        check({tag, "_seg"}, 64'({seg3, seg2, seg1, seg0}), 0);
    endtask

    function automatic logic [15:0] disp();
        return {seg3, seg2, seg1, seg0};
    endfunction

    logic [AW-1:0] exp_a;
    logic [AW-1:0] ra;
    logic [DW-1:0] rdat;
    int            w0, r0;

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        check_all_zero("rst0");
        ar = 1'b1;

        // Manual write/read with a 3-cycle memory ack
        fixed_lat = 3;
        universal_in = 16'h005A;
        press(4'b0001);
        check("man_addr", 64'(a), 64'h05A);
        universal_in = 16'h1234;
        w0 = wr_hi;
        press(4'b0100);
        check("man_wr_done_led_cleared", 64'(done_led), 0);
        wait_done("man_wr", 50);
        check("man_wr_hi_cycles", 64'(wr_hi - w0), 64'(4));
        check("man_wr_addr", 64'(last_wa), 64'h05A);
        check("man_wr_data", 64'(last_wd), 64'h1234);
        check("man_wr_dropped", 64'(wr), 0);
        press(4'b0010);
        wait_done("man_rd", 50);
        check("man_seg3", 64'(seg3), 1);
        check("man_seg2", 64'(seg2), 2);
        check("man_seg1", 64'(seg1), 3);
        check("man_seg0", 64'(seg0), 4);
        check("man_rd_dropped", 64'(rd), 0);

        // Randomised manual write-then-read round trips
        fixed_lat = -1;
        for (int i = 0; i < 4; i++) begin
            ra   = AW'($urandom_range(0, DEPTH - 1));
            rdat = DW'($urandom);
            universal_in = DW'(ra);
            press(4'b0001);
            universal_in = rdat;
            press(4'b0100);
            wait_done("rnd_wr", 50);
            check("rnd_wr_data", 64'(mem[ra]), 64'(rdat));
            press(4'b0010);
            wait_done("rnd_rd", 50);
            check("rnd_rd_disp", 64'(disp()), 64'(rdat));
        end

        // Reset in the middle of a self-test
        in_test = 1;
        press(4'b1000);
        repeat (40) @(negedge clk);
        ar = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst_mid");
        ar = 1'b1;
        in_test = 0;
        repeat (5) @(negedge clk);
        check("rst_idle_wr", 64'(wr), 0);
        check("rst_idle_rd", 64'(rd), 0);

        // Self-test, ideal memory
        universal_in = 16'h005A;
        press(4'b0001);
        exp_a = 10'h05A;
        in_test = 1;
        w0 = wr_cnt;
        r0 = rd_cnt;
        press(4'b1000);
        check("st_pass_done_led_cleared", 64'(done_led), 0);
        wait_done("st_pass", 20000);
        check("st_pass_writes", 64'(wr_cnt - w0), 64'(DEPTH));
        check("st_pass_reads", 64'(rd_cnt - r0), 64'(DEPTH));
        check("st_pass_led", 64'(pass_led), 1);
        check("st_pass_fail_led", 64'(fail_led), 0);
        check("st_pass_disp", 64'(disp()), 0);
        check("st_pass_addr_restored", 64'(a), 64'(exp_a));
        in_test = 0;
        @(negedge clk);

        // Self-test, bit 0 corrupted on reads of address 9
        corrupt_addr = 9;
        in_test = 1;
        w0 = wr_cnt;
        r0 = rd_cnt;
        press(4'b1000);
        wait_done("st_fail", 20000);
        check("st_fail_writes", 64'(wr_cnt - w0), 64'(DEPTH));
        check("st_fail_reads", 64'(rd_cnt - r0), 64'(10));
        check("st_fail_led", 64'(fail_led), 1);
        check("st_fail_pass_led", 64'(pass_led), 0);
        check("st_fail_disp", 64'(disp()), 64'h0009);
        check("st_fail_addr_restored", 64'(a), 64'(exp_a));
        in_test = 0;
        corrupt_addr = -1;
        @(negedge clk);

        // Read that is never acknowledged
        hang_rd = 1;
        r0 = rd_hi;
        press(4'b0010);
        wait_done("tmo", 400);
        check("tmo_rd_hi_cycles", 64'(rd_hi - r0), 64'(TO));
        check("tmo_rd_dropped", 64'(rd), 0);
        check("tmo_fail_led", 64'(fail_led), 1);
        check("tmo_pass_led", 64'(pass_led), 0);
        check("tmo_seg3", 64'(seg3), 64'hD);
        check("tmo_seg2", 64'(seg2), 64'hE);
        check("tmo_seg1", 64'(seg1), 64'hA);
        check("tmo_seg0", 64'(seg0), 64'hD);
        hang_rd = 0;

        // Simultaneous it+wr+rd edges, rd kept held: only the self-test runs
        in_test = 1;
        w0 = wr_cnt;
        r0 = rd_cnt;
        @(negedge clk);
        it_button = 1'b1;
        wr_button = 1'b1;
        rd_button = 1'b1;
        @(negedge clk);
        it_button = 1'b0;
        wr_button = 1'b0;
        check("sim_done_led_cleared", 64'(done_led), 0);
        wait_done("sim", 20000);
        check("sim_writes", 64'(wr_cnt - w0), 64'(DEPTH));
        check("sim_reads", 64'(rd_cnt - r0), 64'(DEPTH));
        check("sim_pass_led", 64'(pass_led), 1);
        check("sim_fail_led", 64'(fail_led), 0);
        in_test = 0;
        r0 = rd_hi;
        repeat (20) @(negedge clk);
        check("sim_held_rd_no_read", 64'(rd_hi - r0), 0);
        rd_button = 1'b0;
        r0 = rd_cnt;
        press(4'b0010);
        wait_done("sim_rd_again", 50);
        check("sim_one_manual_read", 64'(rd_cnt - r0), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
